// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: operand width, divider FSM states,
// divide-by-zero quotient and the sign/zero/parity flag helper shared with the ALU.
package arith_pkg;

    localparam int unsigned WIDTH = 16;
    localparam logic [WIDTH-1:0] DIV0_Q = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic sign;
        logic zero;
        logic parity;
    } flags_t;

    function automatic flags_t calc_flags(input logic [WIDTH-1:0] v);
        flags_t f;
        f.sign   = v[WIDTH-1];
        f.zero   = (v == '0);
        f.parity = ~^v;
        return f;
    endfunction

    function automatic logic [4:0] add4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        return 5'(a) + 5'(b) + 5'(ci);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
module div_step
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p_next,
    output logic [WIDTH-1:0] a_next
);

    localparam int unsigned NIB = WIDTH / 4;

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] nd;
    logic [WIDTH-1:0] diff;
    logic [NIB:0]     carry;
    logic             borrow;

    always_comb begin
        t        = {p, a[WIDTH-1]};
        nd       = ~d;
        carry    = '0;
        carry[0] = 1'b1;
        diff     = '0;
        for (int i = 0; i < NIB; i++) begin
            {carry[i+1], diff[4*i +: 4]} = add4(t[4*i +: 4], nd[4*i +: 4], carry[i]);
        end
        // Top bit adds an inverted zero (a one), so its carry-out collapses to an OR.
        borrow = ~(t[WIDTH] | carry[NIB]);
        if (!borrow) begin
            p_next = diff;
            a_next = {a[WIDTH-2:0], 1'b1};
        end else begin
            p_next = t[WIDTH-1:0];
            a_next = {a[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and ALU-style flags on the quotient.
module div16_seq
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             sign,
    output logic             zero,
    output logic             parity,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, dvs_q, dvs_d, p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div0_q, div0_d;
    logic             busy_d, done_d, ovf_d;
    logic [WIDTH-1:0] q_d, r_d;
    flags_t           flags_q, flags_d;
    logic [WIDTH-1:0] p_nxt, a_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_q),
        .a      (a_q),
        .d      (dvs_q),
        .p_next (p_nxt),
        .a_next (a_nxt)
    );

    // Next-state and next-output logic; a zero divisor parks one cycle in IDLE
    // with div0_q set so its result lands on the edge after the accept.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        div0_d  = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        q_d     = Q;
        r_d     = R;
        flags_d = flags_q;
        ovf_d   = overflow;
        case (state_q)
            IDLE: begin
                if (div0_q) begin
                    q_d     = WIDTH'(DIV0_Q);
                    r_d     = a_q;
                    flags_d = calc_flags(WIDTH'(DIV0_Q));
                    ovf_d   = 1'b1;
                    done_d  = 1'b1;
                end else if (start) begin
                    a_d   = X;
                    dvs_d = Y;
                    p_d   = '0;
                    cnt_d = '0;
                    if (Y != '0) begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        div0_d = 1'b1;
                    end
                end
            end
            RUN: begin
                a_d   = a_nxt;
                p_d   = p_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    q_d     = a_nxt;
                    r_d     = p_nxt;
                    flags_d = calc_flags(a_nxt);
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            dvs_q    <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            div0_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Q        <= '0;
            R        <= '0;
            flags_q  <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            dvs_q    <= dvs_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            div0_q   <= div0_d;
            busy     <= busy_d;
            done     <= done_d;
            Q        <= q_d;
            R        <= r_d;
            flags_q  <= flags_d;
            overflow <= ovf_d;
        end
    end

    assign sign   = flags_q.sign;
    assign zero   = flags_q.zero;
    assign parity = flags_q.parity;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed vector table, handshake and
// reset-abort sequences, and randomized back-to-back divisions against q=x/y, r=x%y.
module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        busy, done, sign, zero, parity, overflow;
    logic [15:0] q, r;

    int errors = 0;
    int checks = 0;

    div16_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .X        (x),
        .Y        (y),
        .busy     (busy),
        .done     (done),
        .Q        (q),
        .R        (r),
        .sign     (sign),
        .zero     (zero),
        .parity   (parity),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vx;
        logic [15:0] vy;
        int          lat;
        logic [15:0] eq;
        logic [15:0] er;
        logic        es;
        logic        ez;
        logic        ep;
        logic        eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero gives all-ones / dividend.
    task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] eq, output logic [15:0] er,
                           output logic es, output logic ez, output logic ep,
                           output logic eo, output int lat);
        if (b == 16'd0) begin
            eq = 16'hFFFF; er = a; eo = 1'b1; lat = 1;
        end else begin
            eq = a / b; er = a % b; eo = 1'b0; lat = 16;
        end
        es = (eq >= 16'h8000);
        ez = (eq == 16'd0);
        ep = ($countones(eq) % 2 == 0);
    endtask

    // Called just after a rising edge; the next edge accepts the request.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        x = a;
        y = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = 16'($urandom);
        y = 16'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic check_op(input string name, input int lat, input bit busy_ok, input int exp_lat,
                            input logic [15:0] eq, input logic [15:0] er,
                            input logic es, input logic ez, input logic ep, input logic eo);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " busy during run"}, 32'(busy_ok), 32'd1);
        chk({name, " busy at done"}, 32'(busy), 32'd0);
        chk({name, " Q"}, 32'(q), 32'(eq));
        chk({name, " R"}, 32'(r), 32'(er));
        chk({name, " flags"}, 32'({sign, zero, parity}), 32'({es, ez, ep}));
        chk({name, " overflow"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        int          lat, elat;
        bit          bok, done_seen, busy_seen;
        logic [15:0] eq, er, na, nb, pa, pb;
        logic        es, ez, ep, eo;

        vecs.push_back('{16'd100,   16'd7,     16, 16'd14,    16'd2, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF,  16'd1,     16, 16'hFFFF,  16'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'd3,     16'd9,     16, 16'd0,     16'd3, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{16'd5,     16'd0,      1, 16'hFFFF,  16'd5, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{16'd1000,  16'd3,     16, 16'd333,   16'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF,  16'hFFFF,  16, 16'd1,     16'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'd0,     16'd5,     16, 16'd0,     16'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{16'h8000,  16'd1,     16, 16'h8000,  16'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Reset state and quiet idle
        #12;
        chk("reset outputs", 32'({busy, done, sign, zero, parity, overflow}), 32'd0);
        chk("reset Q", 32'(q), 32'd0);
        chk("reset R", 32'(r), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        chk("idle no done", 32'(done_seen), 32'd0);
        chk("idle no busy", 32'(busy_seen), 32'd0);

        // Directed vector table, each followed by a result-hold check
        foreach (vecs[i]) begin
            launch(vecs[i].vx, vecs[i].vy);
            wait_done(lat, bok);
            check_op($sformatf("vec%0d", i), lat, bok, vecs[i].lat, vecs[i].eq, vecs[i].er,
                     vecs[i].es, vecs[i].ez, vecs[i].ep, vecs[i].eo);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d hold", i), 32'({q, r}), 32'({vecs[i].eq, vecs[i].er}));
        end

        // start held during RUN with different operands, then accepted in the done cycle
        start = 1'b1;
        x = 16'd100;
        y = 16'd7;
        @(posedge clk);
        #1;
        x = 16'd999;
        y = 16'd2;
        wait_done(lat, bok);
        check_op("held start", lat, bok, 16, 16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bok);
        check_op("done-cycle start", lat, bok, 16, 16'd499, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(16'd50, 16'd5);
        wait_done(lat, bok);
        check_op("back-to-back", lat, bok, 16, 16'd10, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation
        launch(16'd1000, 16'd3);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort outputs", 32'({busy, done, sign, zero, parity, overflow}), 32'd0);
        chk("abort Q/R", 32'({q, r}), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after abort idle", 32'({busy, done}), 32'd0);
        launch(16'd1000, 16'd3);
        wait_done(lat, bok);
        check_op("after abort", lat, bok, 16, 16'd333, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized back-to-back operations, each launched in the previous done cycle
        pa = 16'($urandom);
        pb = 16'($urandom_range(1, 300));
        launch(pa, pb);
        for (int n = 0; n < 60; n++) begin
            wait_done(lat, bok);
            ref_div(pa, pb, eq, er, es, ez, ep, eo, elat);
            check_op($sformatf("rand%0d %0h/%0h", n, pa, pb), lat, bok, elat, eq, er, es, ez, ep, eo);
            na = 16'($urandom);
            case ($urandom_range(0, 3))
                0: nb = 16'd0;
                1: nb = 16'($urandom_range(1, 15));
                2: nb = 16'($urandom);
                default: nb = na >> $urandom_range(0, 15);
            endcase
            pa = na;
            pb = nb;
            if (n < 59) launch(pa, pb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
